// File: rtl/spi_dac_pkg.sv
// Shared types and helpers for the multi-channel SPI DAC sequencer.
package spi_dac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_HOLD  = 3'd2,
    ST_GAP   = 3'd3,
    ST_ACK   = 3'd4,
    ST_CLR   = 3'd5
  } state_t;

  localparam int CLR_CYCLES = 4;

  function automatic int frame_bits(input int cmd_w, input int addr_w,
                                    input int data_w, input int pad_bits);
    return cmd_w + addr_w + data_w + pad_bits;
  endfunction

  // Counter width able to hold max_count-1, never narrower than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/spi_dac_shift.sv
// Frame shifter and SCK divider: each bit is a low phase then a high phase of
// SCK_DIV cycles, followed by one low hold phase with MOSI at zero.
module spi_dac_shift
  import spi_dac_pkg::*;
#(
  parameter int FRAME_BITS = 24,
  parameter int SCK_DIV    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  sck,
  output logic                  mosi,
  output logic                  holding,
  output logic                  done
);

  localparam int BIT_W = cnt_width(FRAME_BITS);
  localparam int DIV_W = cnt_width(SCK_DIV);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_LOW  = 2'd1,
    PH_HIGH = 2'd2,
    PH_HOLD = 2'd3
  } phase_t;

  phase_t                phase_r, phase_nxt;
  logic [FRAME_BITS-1:0] sreg_r, sreg_nxt, word_s;
  logic [BIT_W-1:0]      bit_r, bit_nxt;
  logic [DIV_W-1:0]      div_r, div_nxt;
  logic                  sck_r, sck_nxt;
  logic                  mosi_r, mosi_nxt;
  logic                  div_zero_s;

  // Phase sequencing; sreg holds the bits not yet placed on MOSI.
  always_comb begin
    phase_nxt  = phase_r;
    sreg_nxt   = sreg_r;
    bit_nxt    = bit_r;
    div_nxt    = div_r;
    sck_nxt    = sck_r;
    mosi_nxt   = mosi_r;
    div_zero_s = (div_r == DIV_ZERO);
    word_s     = load ? frame : sreg_r;
    case (phase_r)
      PH_IDLE: begin
        if (start) begin
          phase_nxt = PH_LOW;
          sck_nxt   = 1'b0;
          mosi_nxt  = word_s[FRAME_BITS-1];
          sreg_nxt  = {word_s[FRAME_BITS-2:0], 1'b0};
          bit_nxt   = BIT_LAST;
          div_nxt   = DIV_LAST;
        end else if (load) begin
          sreg_nxt = frame;
        end else begin
          sck_nxt = 1'b0;
        end
      end
      PH_LOW: begin
        if (div_zero_s) begin
          phase_nxt = PH_HIGH;
          sck_nxt   = 1'b1;
          div_nxt   = DIV_LAST;
        end else begin
          div_nxt = div_r - DIV_ONE;
        end
      end
      PH_HIGH: begin
        if (div_zero_s) begin
          sck_nxt = 1'b0;
          div_nxt = DIV_LAST;
          if (bit_r == BIT_ZERO) begin
            phase_nxt = PH_HOLD;
            mosi_nxt  = 1'b0;
          end else begin
            phase_nxt = PH_LOW;
            mosi_nxt  = sreg_r[FRAME_BITS-1];
            sreg_nxt  = {sreg_r[FRAME_BITS-2:0], 1'b0};
            bit_nxt   = bit_r - BIT_ONE;
          end
        end else begin
          div_nxt = div_r - DIV_ONE;
        end
      end
      PH_HOLD: begin
        if (div_zero_s) begin
          phase_nxt = PH_IDLE;
        end else begin
          div_nxt = div_r - DIV_ONE;
        end
      end
      default: begin
        phase_nxt = PH_IDLE;
        sck_nxt   = 1'b0;
        mosi_nxt  = 1'b0;
      end
    endcase
  end

  // Shifter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r <= PH_IDLE;
      sreg_r  <= {FRAME_BITS{1'b0}};
      bit_r   <= BIT_ZERO;
      div_r   <= DIV_ZERO;
      sck_r   <= 1'b0;
      mosi_r  <= 1'b0;
    end else begin
      phase_r <= phase_nxt;
      sreg_r  <= sreg_nxt;
      bit_r   <= bit_nxt;
      div_r   <= div_nxt;
      sck_r   <= sck_nxt;
      mosi_r  <= mosi_nxt;
    end
  end

  assign sck     = sck_r;
  assign mosi    = mosi_r;
  assign holding = (phase_r == PH_HOLD);
  assign done    = (phase_r == PH_HOLD) && div_zero_s;

endmodule

// File: rtl/spi_dac_seq.sv
// Multi-channel SPI DAC sequencer: one dav/ack request streams one frame per
// enabled channel. Define SPI_DAC_SEQ_CLR_EN to add the dacclr clear pulse.
module spi_dac_seq
  import spi_dac_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int CMD_W    = 4,
  parameter int ADDR_W   = 4,
  parameter int NCH      = 4,
  parameter int PAD_BITS = 4,
  parameter int SCK_DIV  = 1,
  parameter int CS_GAP   = 2
) (
  input  logic                  dacclk,
  input  logic                  dacrst,
`ifdef SPI_DAC_SEQ_CLR_EN
  input  logic                  dacclr,
`endif
  input  logic                  dacdav,
  output logic                  davdac,
  input  logic [CMD_W-1:0]      daccmd,
  input  logic [NCH-1:0]        dacmask,
  input  logic [NCH*DATA_W-1:0] dacdata,
  output logic                  dacbusy,
  output logic                  dacsck,
  output logic                  dacspid,
  output logic                  csdac,
  output logic                  clrdac
);

  localparam int FRAME_BITS = frame_bits(CMD_W, ADDR_W, DATA_W, PAD_BITS);
  localparam int GAP_W      = cnt_width(CS_GAP);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_ZERO = GAP_W'(0);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  state_t                state_r, state_nxt;
  logic                  cs_r, cs_nxt;
  logic                  ack_r, ack_nxt;
  logic                  busy_r, busy_nxt;
  logic                  lost_r, lost_nxt;
  logic [NCH-1:0]        mask_r, mask_nxt;
  logic [CMD_W-1:0]      cmd_r, cmd_nxt;
  logic [NCH*DATA_W-1:0] data_r, data_nxt;
  logic [GAP_W-1:0]      gap_r, gap_nxt;

  logic                  start_s, holding_s, done_s, found_s;
  logic [CMD_W-1:0]      src_cmd_s;
  logic [NCH-1:0]        src_mask_s, rest_s;
  logic [NCH*DATA_W-1:0] src_data_s;
  logic [ADDR_W-1:0]     sel_s;
  logic [DATA_W-1:0]     chan_s;
  logic [FRAME_BITS-1:0] frame_s;

`ifdef SPI_DAC_SEQ_CLR_EN
  localparam int CLR_W = cnt_width(CLR_CYCLES);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  localparam logic [CLR_W-1:0] CLR_ZERO = CLR_W'(0);
  localparam logic [CLR_W-1:0] CLR_ONE  = CLR_W'(1);
  logic             clr_r, clr_nxt;
  logic [CLR_W-1:0] clr_cnt_r, clr_cnt_nxt;
`endif

  // Lowest remaining channel; in IDLE the live inputs feed the accept edge.
  always_comb begin
    src_cmd_s  = (state_r == ST_IDLE) ? daccmd  : cmd_r;
    src_mask_s = (state_r == ST_IDLE) ? dacmask : mask_r;
    src_data_s = (state_r == ST_IDLE) ? dacdata : data_r;
    sel_s      = {ADDR_W{1'b0}};
    chan_s     = {DATA_W{1'b0}};
    rest_s     = src_mask_s;
    found_s    = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (src_mask_s[i] && !found_s) begin
        found_s   = 1'b1;
        sel_s     = ADDR_W'(i);
        chan_s    = src_data_s[i*DATA_W +: DATA_W];
        rest_s[i] = 1'b0;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign frame_s = {src_cmd_s, sel_s, chan_s, {PAD_BITS{1'b0}}};

  // Sequencer next state: accept, per-frame completion, gap, ack handshake.
  always_comb begin
    state_nxt = state_r;
    cs_nxt    = cs_r;
    ack_nxt   = ack_r;
    busy_nxt  = busy_r;
    lost_nxt  = lost_r;
    mask_nxt  = mask_r;
    cmd_nxt   = cmd_r;
    data_nxt  = data_r;
    gap_nxt   = gap_r;
    start_s   = 1'b0;
`ifdef SPI_DAC_SEQ_CLR_EN
    clr_nxt     = clr_r;
    clr_cnt_nxt = clr_cnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        lost_nxt = 1'b0;
`ifdef SPI_DAC_SEQ_CLR_EN
        if (dacclr) begin
          state_nxt   = ST_CLR;
          clr_nxt     = 1'b0;
          clr_cnt_nxt = CLR_LAST;
          busy_nxt    = 1'b1;
        end else
`endif
        if (dacdav && !ack_r) begin
          busy_nxt = 1'b1;
          cmd_nxt  = daccmd;
          data_nxt = dacdata;
          if (dacmask != {NCH{1'b0}}) begin
            start_s   = 1'b1;
            cs_nxt    = 1'b0;
            mask_nxt  = rest_s;
            state_nxt = ST_SHIFT;
          end else begin
            ack_nxt   = 1'b1;
            state_nxt = ST_ACK;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT, ST_HOLD: begin
        lost_nxt = lost_r | ~dacdav;
        if (done_s) begin
          cs_nxt = 1'b1;
          if (mask_r != {NCH{1'b0}}) begin
            state_nxt = ST_GAP;
            gap_nxt   = GAP_LAST;
          end else if (dacdav && !lost_r) begin
            ack_nxt   = 1'b1;
            state_nxt = ST_ACK;
          end else begin
            busy_nxt  = 1'b0;
            state_nxt = ST_IDLE;
          end
        end else if (holding_s) begin
          state_nxt = ST_HOLD;
        end else begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_GAP: begin
        lost_nxt = lost_r | ~dacdav;
        if (gap_r == GAP_ZERO) begin
          start_s   = 1'b1;
          cs_nxt    = 1'b0;
          mask_nxt  = rest_s;
          state_nxt = ST_SHIFT;
        end else begin
          gap_nxt = gap_r - GAP_ONE;
        end
      end
      ST_ACK: begin
        if (!dacdav) begin
          ack_nxt   = 1'b0;
          busy_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end else begin
          ack_nxt = 1'b1;
        end
      end
`ifdef SPI_DAC_SEQ_CLR_EN
      ST_CLR: begin
        if (clr_cnt_r == CLR_ZERO) begin
          clr_nxt   = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end else begin
          clr_cnt_nxt = clr_cnt_r - CLR_ONE;
        end
      end
`endif
      default: begin
        state_nxt = ST_IDLE;
        cs_nxt    = 1'b1;
        ack_nxt   = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge dacclk) begin
    if (dacrst) begin
      state_r <= ST_IDLE;
      cs_r    <= 1'b1;
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
      lost_r  <= 1'b0;
      mask_r  <= {NCH{1'b0}};
      cmd_r   <= {CMD_W{1'b0}};
      data_r  <= {(NCH*DATA_W){1'b0}};
      gap_r   <= GAP_ZERO;
`ifdef SPI_DAC_SEQ_CLR_EN
      clr_r     <= 1'b1;
      clr_cnt_r <= CLR_ZERO;
`endif
    end else begin
      state_r <= state_nxt;
      cs_r    <= cs_nxt;
      ack_r   <= ack_nxt;
      busy_r  <= busy_nxt;
      lost_r  <= lost_nxt;
      mask_r  <= mask_nxt;
      cmd_r   <= cmd_nxt;
      data_r  <= data_nxt;
      gap_r   <= gap_nxt;
`ifdef SPI_DAC_SEQ_CLR_EN
      clr_r     <= clr_nxt;
      clr_cnt_r <= clr_cnt_nxt;
`endif
    end
  end

  spi_dac_shift #(
    .FRAME_BITS(FRAME_BITS),
    .SCK_DIV   (SCK_DIV)
  ) u_shift (
    .clk    (dacclk),
    .rst    (dacrst),
    .load   (start_s),
    .start  (start_s),
    .frame  (frame_s),
    .sck    (dacsck),
    .mosi   (dacspid),
    .holding(holding_s),
    .done   (done_s)
  );

  assign davdac  = ack_r;
  assign dacbusy = busy_r;
  assign csdac   = cs_r;
`ifdef SPI_DAC_SEQ_CLR_EN
  assign clrdac = clr_r;
`else
  assign clrdac = 1'b1;
`endif

endmodule

// File: tb/tb_spi_dac_seq.sv
// Directed self-checking bench for spi_dac_seq (default DUT plus an SCK_DIV=3 DUT).
module tb_spi_dac_seq;

  logic        clk;
  logic        dacrst;
  logic        dacdav, dacdav2;
  logic [3:0]  daccmd, daccmd2;
  logic [3:0]  dacmask, dacmask2;
  logic [47:0] dacdata, dacdata2;
  logic        davdac, dacbusy, dacsck, dacspid, csdac, clrdac;
  logic        davdac2, dacbusy2, dacsck2, dacspid2, csdac2, clrdac2;
`ifdef SPI_DAC_SEQ_CLR_EN
  logic        dacclr, dacclr2;
`endif

  int pass_cnt = 0;
  int fail_cnt = 0;

  logic [23:0] bits;
  int          pre, low, nsck, viol;

  spi_dac_seq dut (
    .dacclk (clk),
    .dacrst (dacrst),
`ifdef SPI_DAC_SEQ_CLR_EN
    .dacclr (dacclr),
`endif
    .dacdav (dacdav),
    .davdac (davdac),
    .daccmd (daccmd),
    .dacmask(dacmask),
    .dacdata(dacdata),
    .dacbusy(dacbusy),
    .dacsck (dacsck),
    .dacspid(dacspid),
    .csdac  (csdac),
    .clrdac (clrdac)
  );

  spi_dac_seq #(.SCK_DIV(3)) dut2 (
    .dacclk (clk),
    .dacrst (dacrst),
`ifdef SPI_DAC_SEQ_CLR_EN
    .dacclr (dacclr2),
`endif
    .dacdav (dacdav2),
    .davdac (davdac2),
    .daccmd (daccmd2),
    .dacmask(dacmask2),
    .dacdata(dacdata2),
    .dacbusy(dacbusy2),
    .dacsck (dacsck2),
    .dacspid(dacspid2),
    .csdac  (csdac2),
    .clrdac (clrdac2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input bit sel, input logic [3:0] cmd, input logic [3:0] mask,
                     input logic [47:0] data);
    @(posedge clk); #1;
    if (sel) begin
      daccmd2 = cmd; dacmask2 = mask; dacdata2 = data; dacdav2 = 1'b1;
    end else begin
      daccmd = cmd; dacmask = mask; dacdata = data; dacdav = 1'b1;
    end
  endtask

  task automatic drop(input bit sel);
    @(posedge clk); #1;
    if (sel) dacdav2 = 1'b0;
    else dacdav = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // mode: 0 plain, 1 change inputs mid-frame, 2 drop dav mid-frame, 3 reset at bit 10
  task automatic capture(input bit sel, input int mode, output logic [23:0] b,
                         output int n_pre, output int n_low, output int n_sck, output int n_viol);
    logic cs_v, sck_v, sd_v, prev_sck, prev_sd;
    b = 24'h0; n_pre = 0; n_low = 0; n_sck = 0; n_viol = 0;
    cs_v = sel ? csdac2 : csdac;
    while (cs_v && n_pre < 400) begin
      if (sel ? dacsck2 : dacsck) n_viol++;
      n_pre++;
      @(negedge clk);
      cs_v = sel ? csdac2 : csdac;
    end
    prev_sck = 1'b0;
    prev_sd  = sel ? dacspid2 : dacspid;
    while (!cs_v && n_low < 2000) begin
      sck_v = sel ? dacsck2 : dacsck;
      sd_v  = sel ? dacspid2 : dacspid;
      if (sck_v && !prev_sck) begin
        b = {b[22:0], sd_v};
        n_sck++;
        if (mode == 3 && n_sck == 10) begin
          dacrst = 1'b1;
          dacdav = 1'b0;
        end
      end
      if (sd_v !== prev_sd && !(prev_sck && !sck_v)) n_viol++;
      if (mode == 1 && n_low == 20) begin
        dacdata = 48'hFFFF_FFFF_FFFF; daccmd = 4'hF; dacmask = 4'hF;
      end
      if (mode == 2 && n_low == 20) dacdav = 1'b0;
      prev_sck = sck_v;
      prev_sd  = sd_v;
      n_low++;
      @(negedge clk);
      cs_v = sel ? csdac2 : csdac;
    end
    if (sel ? dacsck2 : dacsck) n_viol++;
  endtask

  initial begin
    dacrst = 1'b1;
    dacdav = 1'b0; daccmd = 4'h0; dacmask = 4'h0; dacdata = 48'h0;
    dacdav2 = 1'b0; daccmd2 = 4'h0; dacmask2 = 4'h0; dacdata2 = 48'h0;
`ifdef SPI_DAC_SEQ_CLR_EN
    dacclr = 1'b0; dacclr2 = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 dacrst = 1'b0;
    @(negedge clk);
    check("rst_davdac", {31'd0, davdac}, 32'd0);
    check("rst_busy",   {31'd0, dacbusy}, 32'd0);
    check("rst_sck",    {31'd0, dacsck}, 32'd0);
    check("rst_spid",   {31'd0, dacspid}, 32'd0);
    check("rst_cs",     {31'd0, csdac}, 32'd1);
    check("rst_clr",    {31'd0, clrdac}, 32'd1);
    check("rst_cs2",    {30'd0, csdac2, clrdac2}, 32'd3);

    // Single frame: cmd 3, ch0 = ABC
    req(1'b0, 4'b0011, 4'b0001, {36'h0, 12'hABC});
    capture(1'b0, 0, bits, pre, low, nsck, viol);
    check("t1_frame", {8'd0, bits}, 32'h0030ABC0);
    check("t1_cslow", low, 32'd49);
    check("t1_nsck",  nsck, 32'd24);
    check("t1_viol",  viol, 32'd0);
    check("t1_ack",   {31'd0, davdac}, 32'd1);
    check("t1_busy",  {31'd0, dacbusy}, 32'd1);
    drop(1'b0);
    check("t1_ack_off",  {31'd0, davdac}, 32'd0);
    check("t1_busy_off", {31'd0, dacbusy}, 32'd0);

    // Two channels, mask 1010
    req(1'b0, 4'b0011, 4'b1010, {12'hFED, 12'h555, 12'h123, 12'h777});
    capture(1'b0, 0, bits, pre, low, nsck, viol);
    check("t2_frame_a", {8'd0, bits}, 32'h00311230);
    check("t2_cslow_a", low, 32'd49);
    check("t2_ack_mid", {31'd0, davdac}, 32'd0);
    capture(1'b0, 0, bits, pre, low, nsck, viol);
    check("t2_gap",     pre, 32'd2);
    check("t2_frame_b", {8'd0, bits}, 32'h0033FED0);
    check("t2_cslow_b", low, 32'd49);
    check("t2_ack",     {31'd0, davdac}, 32'd1);
    drop(1'b0);

    // Inputs change mid-frame
    req(1'b0, 4'b0111, 4'b0001, {36'h0, 12'h5A5});
    capture(1'b0, 1, bits, pre, low, nsck, viol);
    check("t3_frame", {8'd0, bits}, 32'h00705A50);
    check("t3_ack",   {31'd0, davdac}, 32'd1);
    drop(1'b0);

    // dav dropped mid-frame
    req(1'b0, 4'b0011, 4'b0001, {36'h0, 12'hABC});
    capture(1'b0, 2, bits, pre, low, nsck, viol);
    check("t4_frame", {8'd0, bits}, 32'h0030ABC0);
    check("t4_ack",   {31'd0, davdac}, 32'd0);
    check("t4_busy",  {31'd0, dacbusy}, 32'd0);
    @(negedge clk);
    check("t4_ack_after", {30'd0, davdac, dacbusy}, 32'd0);

    // Reset at bit 10, then a fresh request
    req(1'b0, 4'b0011, 4'b0001, {36'h0, 12'hABC});
    capture(1'b0, 3, bits, pre, low, nsck, viol);
    check("t5_nsck",  nsck, 32'd10);
    check("t5_cs",    {31'd0, csdac}, 32'd1);
    check("t5_sck",   {31'd0, dacsck}, 32'd0);
    check("t5_ack",   {31'd0, davdac}, 32'd0);
    check("t5_busy",  {31'd0, dacbusy}, 32'd0);
    @(posedge clk); #1 dacrst = 1'b0;
    req(1'b0, 4'b0001, 4'b0100, {12'h0, 12'h0F0, 24'h0});
    capture(1'b0, 0, bits, pre, low, nsck, viol);
    check("t5_frame", {8'd0, bits}, 32'h00120F00);
    check("t5_cslow", low, 32'd49);
    check("t5_nsck2", nsck, 32'd24);
    drop(1'b0);

    // Empty mask
    @(posedge clk); #1;
    dacmask = 4'b0000; dacdav = 1'b1;
    @(negedge clk);
    check("t6_ack_early", {31'd0, davdac}, 32'd0);
    @(negedge clk);
    check("t6_ack",  {31'd0, davdac}, 32'd1);
    check("t6_cs",   {31'd0, csdac}, 32'd1);
    check("t6_busy", {31'd0, dacbusy}, 32'd1);
    drop(1'b0);
    check("t6_ack_off", {31'd0, davdac}, 32'd0);

    // SCK_DIV = 3 instance
    req(1'b1, 4'b0011, 4'b0001, {36'h0, 12'hABC});
    capture(1'b1, 0, bits, pre, low, nsck, viol);
    check("t7_frame", {8'd0, bits}, 32'h0030ABC0);
    check("t7_cslow", low, 32'd147);
    check("t7_nsck",  nsck, 32'd24);
    check("t7_viol",  viol, 32'd0);
    check("t7_ack",   {30'd0, davdac2, dacbusy2}, 32'd3);
    drop(1'b1);
    check("t7_ack_off", {31'd0, davdac2}, 32'd0);

`ifdef SPI_DAC_SEQ_CLR_EN
    // Clear pulse wins over a simultaneous request
    @(posedge clk); #1;
    dacclr = 1'b1; dacdav = 1'b1; dacmask = 4'b0001; daccmd = 4'b0011;
    dacdata = {36'h0, 12'hABC};
    @(posedge clk); #1 dacclr = 1'b0;
    low = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!clrdac) low++;
    end
    check("t8_clr_len", low, 32'd4);
    check("t8_cs_hold", {31'd0, csdac}, 32'd1);
    capture(1'b0, 0, bits, pre, low, nsck, viol);
    check("t8_frame", {8'd0, bits}, 32'h0030ABC0);
    drop(1'b0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule

// File: doc/spi_dac_seq.md
Name: spi_dac_seq

Overview:
- Parametrised multi-channel successor to the single-shot SPI DAC driver for the Spartan-3E starter board DAC (LTC2624-class, 24-bit frames).
- One request streams up to NCH frames, one per channel selected in a mask.
- Word width, SCK rate, padding and inter-frame gap are configurable; request data is captured at accept.
- Sits between application logic (dav/ack level handshake) and the board DAC pins.

Parameters:
- DATA_W, 12, DAC sample width per channel.
- CMD_W, 4, command field width.
- ADDR_W, 4, address field width; channel i is sent with address i.
- NCH, 4, channel count (1..2**ADDR_W).
- PAD_BITS, 4, trailing don't-care bits per frame, sent as 0.
- SCK_DIV, 1, SCK half-period in dacclk cycles (>=1).
- CS_GAP, 2, dacclk cycles CS stays high between frames (>=1).

Ports:
- dacclk  in  1  system clock.
- dacrst  in  1  synchronous active-high reset.
- dacdav  in  1  request valid (level).
- davdac  out  1  request acknowledge (level).
- daccmd  in  CMD_W  command applied to every frame.
- dacmask  in  NCH  channel enable bits.
- dacdata  in  NCH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- dacbusy  out  1  high from accept until return to IDLE.
- dacsck  out  1  SPI clock.
- dacspid  out  1  SPI MOSI.
- csdac  out  1  chip select, active low.
- clrdac  out  1  DAC clear, active low.

Behaviour:
- Reset (synchronous, dacrst=1 at posedge) and reset mid-frame: next cycle davdac=0, dacbusy=0, dacsck=0, dacspid=0, csdac=1, clrdac=1; state IDLE. The frame is abandoned.
- Frame layout: FRAME_BITS = CMD_W+ADDR_W+DATA_W+PAD_BITS (24 by default). Bits are sent MSB first: cmd, addr, data, then pad zeros.
- States: IDLE, SHIFT, HOLD, GAP, ACK.
- IDLE -> SHIFT: taken when dacdav=1 and davdac=0 and dacmask!=0. The same edge captures daccmd, dacmask and dacdata; later input changes are ignored. dacbusy=1. The lowest set mask bit is selected.
- Empty mask: dacdav=1 with dacmask=0 -> ACK next cycle. No CS activity.
- SHIFT:
  - The cycle after accept: csdac=0, dacsck=0, dacspid=frame MSB.
  - Each bit is a low phase of SCK_DIV cycles (data stable) followed by a high phase of SCK_DIV cycles (DAC samples on rising edge).
  - The next bit is driven together with the falling edge.
- HOLD: after the last high phase, dacsck=0 and dacspid=0 for SCK_DIV cycles. csdac low time per frame = (2*FRAME_BITS+1)*SCK_DIV cycles (49 at defaults).
- Frame end: csdac=1.
  - If more mask bits remain: GAP for CS_GAP cycles, then SHIFT on the next set bit, in ascending order.
  - Otherwise: ACK, with davdac=1 on the same edge csdac rises.
- dacdav dropped mid-sequence: the sequence still completes with no abort. At completion davdac stays 0 and the block returns to IDLE.
- ACK: davdac holds 1 while dacdav=1. The cycle after dacdav=0 is sampled, davdac=0, dacbusy=0, state IDLE. A new request needs dacdav low then high.
- dacsck is always 0 whenever csdac=1. The bit and divider counters are sized $clog2 of their maxima and wrap only via explicit reload.
- clrdac is held 1 unless the optional feature is compiled in.

Optional Feature:
- Macro: SPI_DAC_SEQ_CLR_EN.
- With it:
  - Adds input dacclr (1 bit).
  - dacclr=1 in IDLE drives clrdac=0 for exactly 4 cycles, with dacbusy=1 and no request accepted during that time.
  - dacclr outside IDLE is ignored.
  - If dacclr and dacdav are both high in IDLE, clear wins and the request is accepted afterward.
- Without it: no dacclr port; clrdac is a constant 1.

Decomposition:
- Package spi_dac_pkg: state enum, FRAME_BITS computation function, CLR_CYCLES=4 constant.
- Sub-module spi_dac_shift: frame shift register plus SCK divider. Inputs: load, frame word, start. Outputs: sck, mosi, done.
- Top level holds the channel sequencer, mask scan and handshake.

Test Plan:
- Defaults, mask=4'b0001, cmd=4'b0011, ch0=12'hABC -> one frame, 24 rising SCKs, sampled bits 0011_0000_1010_1011_1100_0000. csdac low 49 cycles. davdac rises with csdac.
- mask=4'b1010 -> two frames with addr 0001 then 0011, CS high 2 cycles between them. Total dacbusy = 1+49+2+49+1 cycles until ACK.
- SCK_DIV=3 -> each SCK phase is 3 cycles; dacspid changes only on falling SCK.
- dacdata changed mid-frame, and separately dacdav dropped mid-frame -> transmitted bits unchanged; in the dropped case the sequence completes, davdac stays 0, and the block returns to IDLE.
- dacrst asserted at bit 10 -> next cycle csdac=1, dacsck=0, davdac=0. A new request then sends a full, correct frame.
- mask=0 -> davdac=1 one cycle after dav with no CS pulse. With SPI_DAC_SEQ_CLR_EN, dacclr pulse -> clrdac low for exactly 4 cycles.
